// File: rtl/bias_add_8.sv
// bias_add_8: per-frame bias load followed by bias add, shift and
// saturate of a channel-interleaved accumulator stream.
// Ports: ap_clk, ap_rst_n (sync, active low);
//   bias_V_dout/empty_n/read   : bias coefficient FIFO (input)
//   input_V_dout/empty_n/read  : accumulator FIFO (input)
//   output_V_din/full_n/write  : result FIFO (output)
module bias_add_8 #(
   parameter int N_KERN  = 16,
   parameter int PIXELS  = 64,
   parameter int COEFF_W = 16,
   parameter int ACC_W   = 32,
   parameter int OUT_W   = 16,
   parameter int SHIFT   = 0
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic [COEFF_W-1:0] bias_V_dout,
   input  logic               bias_V_empty_n,
   output logic               bias_V_read,
   input  logic [ACC_W-1:0]   input_V_dout,
   input  logic               input_V_empty_n,
   output logic               input_V_read,
   output logic [OUT_W-1:0]   output_V_din,
   input  logic               output_V_full_n,
   output logic               output_V_write
);

   localparam int CW = (N_KERN > 1) ? $clog2(N_KERN) : 1;
   localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(N_KERN - 1);
   localparam logic [PW-1:0] P_LAST = PW'(PIXELS - 1);

   // Saturation bounds expressed at the full sum width
   localparam logic signed [ACC_W:0] S_MAX =
      {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] S_MIN =
      {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] O_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic [0:0] {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_bias_cnt;
   logic [CW-1:0]      r_ch_cnt;
   logic [PW-1:0]      r_pix_cnt;
   logic               r_out_valid;
   logic [OUT_W-1:0]   r_dout;
   logic [COEFF_W-1:0] r_bias [N_KERN];

   logic                    w_bias_rd;
   logic                    w_accept;
   logic                    w_write;
   logic [COEFF_W-1:0]      w_bias;
   logic signed [ACC_W:0]   w_acc_x;
   logic signed [ACC_W:0]   w_bias_x;
   logic signed [ACC_W:0]   w_sum;
   logic signed [ACC_W:0]   w_sh;
   logic [OUT_W-1:0]        w_res;

   assign w_bias_rd = (r_state == S_LOAD) && bias_V_empty_n;
   assign w_write   = r_out_valid && output_V_full_n;
   // A new sample may enter when the output slot is free or drains now
   assign w_accept  = (r_state == S_RUN) && input_V_empty_n &&
                      (!r_out_valid || output_V_full_n);

   assign w_bias   = r_bias[r_ch_cnt];
   assign w_acc_x  = {input_V_dout[ACC_W-1], input_V_dout};
   assign w_bias_x = {{(ACC_W+1-COEFF_W){w_bias[COEFF_W-1]}}, w_bias};
   assign w_sum    = w_acc_x + w_bias_x;
   assign w_sh     = w_sum >>> SHIFT;

   always_comb begin
      w_res = w_sh[OUT_W-1:0];
      if (w_sh > S_MAX)
         w_res = O_MAX;
      else if (w_sh < S_MIN)
         w_res = O_MIN;
   end

   assign bias_V_read    = w_bias_rd;
   assign input_V_read   = w_accept;
   assign output_V_write = w_write;
   assign output_V_din   = r_dout;

   // Coefficient store is not reset; each LOAD overwrites it
   always_ff @(posedge ap_clk) begin
      if (ap_rst_n && w_bias_rd)
         r_bias[r_bias_cnt] <= bias_V_dout;
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state     <= S_LOAD;
         r_bias_cnt  <= '0;
         r_ch_cnt    <= '0;
         r_pix_cnt   <= '0;
         r_out_valid <= 1'b0;
         r_dout      <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_bias_rd) begin
                  if (r_bias_cnt == C_LAST) begin
                     r_bias_cnt <= '0;
                     r_state    <= S_RUN;
                  end else begin
                     r_bias_cnt <= r_bias_cnt + 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (r_ch_cnt == C_LAST) begin
                     r_ch_cnt <= '0;
                     if (r_pix_cnt == P_LAST) begin
                        r_pix_cnt <= '0;
                        r_state   <= S_LOAD;
                     end else begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                     end
                  end else begin
                     r_ch_cnt <= r_ch_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= S_LOAD;
         endcase

         if (w_accept) begin
            r_dout      <= w_res;
            r_out_valid <= 1'b1;
         end else if (w_write) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bias_add_8.sv
// tb_bias_add_8: random and directed frames through two instances
// (SHIFT=0 and SHIFT=4) checked against a frame-level arithmetic model.
module tb_bias_add_8;

   localparam int NK = 16;
   localparam int PX = 64;
   localparam int FR = NK * PX;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] b_dout;
   logic        b_en;
   logic        b_rd0, b_rd4;
   logic [31:0] i_dout;
   logic        i_en;
   logic        i_rd0, i_rd4;
   logic [15:0] o_din0, o_din4;
   logic        full_n;
   logic        wr0, wr4;

   always #5 clk = ~clk;

   bias_add_8 #(.SHIFT(0)) u_dut0 (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .bias_V_dout(b_dout), .bias_V_empty_n(b_en), .bias_V_read(b_rd0),
      .input_V_dout(i_dout), .input_V_empty_n(i_en), .input_V_read(i_rd0),
      .output_V_din(o_din0), .output_V_full_n(full_n), .output_V_write(wr0)
   );

   bias_add_8 #(.SHIFT(4)) u_dut4 (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .bias_V_dout(b_dout), .bias_V_empty_n(b_en), .bias_V_read(b_rd4),
      .input_V_dout(i_dout), .input_V_empty_n(i_en), .input_V_read(i_rd4),
      .output_V_din(o_din4), .output_V_full_n(full_n), .output_V_write(wr4)
   );

   logic [15:0] bq[$];
   logic [31:0] iq[$];
   logic [15:0] e0[$];
   logic [15:0] e4[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int full_pat = 0;
   bit rnd_in = 0;
   int gap = 0;
   int gate_at = -1;
   int bpops = 0;
   bit force_rst = 1;
   bit rst_arm = 0;
   bit post_rst = 0;
   int facc = 0;
   int acc_n = 0;
   int wr_n = 0;
   int first_wr = -1;
   int last_wr = -1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_out(input logic [31:0] x,
                                           input logic [15:0] b,
                                           input int sh);
      longint s;
      s = longint'($signed(x)) + longint'($signed(b));
      s = s >>> sh;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      return s[15:0];
   endfunction

   // mode 0: biases 0..15, inputs 100; 1: directed corners; else random
   task automatic push_frame(input int mode);
      logic [15:0] b [NK];
      logic [31:0] x;
      for (int k = 0; k < NK; k++) begin
         b[k] = (mode == 0) ? 16'(k) : 16'($urandom);
      end
      if (mode == 1) begin
         b[0] = 16'h7FFF; b[1] = 16'hFFFF; b[2] = 16'hFFF9;
         b[3] = 16'h0010; b[4] = 16'h0000;
      end
      for (int k = 0; k < NK; k++) bq.push_back(b[k]);
      for (int j = 0; j < FR; j++) begin
         if (mode == 0)
            x = 32'd100;
         else if ($urandom_range(3) == 0)
            x = $urandom;
         else
            x = 32'($signed(18'($urandom)));
         if (mode == 1) begin
            case (j)
               0: x = 32'h7FFF0000;
               1: x = 32'h80000000;
               2: x = 32'd5;
               3: x = 32'h00000100;
               4: x = -32'sd33;
               default: ;
            endcase
         end
         iq.push_back(x);
         e0.push_back(ref_out(x, b[j % NK], 0));
         e4.push_back(ref_out(x, b[j % NK], 4));
      end
   endtask

   task automatic cycle();
      bit s_brd, s_ird, s_wr0, s_wr4, s_rst;
      @(negedge clk);
      cyc++;
      case (full_pat)
         1: full_n = ((cyc % 4) == 3);
         2: full_n = ($urandom_range(3) != 0);
         default: full_n = 1'b1;
      endcase
      b_en   = (bq.size() > 0) && (gap == 0);
      b_dout = (bq.size() > 0) ? bq[0] : 16'h0;
      i_en   = (iq.size() > 0) && (!rnd_in || $urandom_range(3) != 0);
      i_dout = (iq.size() > 0) ? iq[0] : 32'h0;
      rst_n  = !(force_rst || (rst_arm && facc == 300));
      #1;
      if (post_rst) begin
         chk("rst_wr0", wr0, 0);
         chk("rst_wr4", wr4, 0);
         chk("rst_din0", o_din0, 0);
         chk("rst_din4", o_din4, 0);
         post_rst = 0;
      end
      if (wr0) begin
         chk("wr_full0", full_n, 1);
         if (e0.size() > 0) chk("out0", o_din0, e0[0]);
         else chk("extra0", wr0, 0);
      end
      if (wr4) begin
         chk("wr_full4", full_n, 1);
         if (e4.size() > 0) chk("out4", o_din4, e4[0]);
         else chk("extra4", wr4, 0);
      end
      if (gap > 0) begin
         chk("gap_brd", b_rd0, 0);
         chk("gap_ird", i_rd0, 0);
      end
      if (rst_n && !full_n && acc_n > wr_n)
         chk("hold_ird", i_rd0, 0);
      s_brd = b_rd0; s_ird = i_rd0; s_wr0 = wr0; s_wr4 = wr4;
      s_rst = !rst_n;
      @(posedge clk);
      if (gap > 0) gap--;
      if (s_rst) begin
         bq.delete(); iq.delete(); e0.delete(); e4.delete();
         facc = 0; acc_n = 0; wr_n = 0;
         rst_arm = 0; post_rst = 1;
      end else begin
         if (s_brd && bq.size() > 0) begin
            void'(bq.pop_front());
            bpops++;
            if (bpops == gate_at) gap = 10;
         end
         if (s_ird && iq.size() > 0) begin
            void'(iq.pop_front());
            acc_n++;
            facc = (facc + 1) % FR;
         end
         if (s_wr0) begin
            if (e0.size() > 0) void'(e0.pop_front());
            wr_n++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
         end
         if (s_wr4 && e4.size() > 0) void'(e4.pop_front());
      end
   endtask

   task automatic run_until_empty(input string tag, input int budget);
      int n = 0;
      while ((e0.size() != 0 || e4.size() != 0 || iq.size() != 0)
             && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, 32'(e0.size() + e4.size()), 0);
   endtask

   initial begin
      full_n = 1'b1; b_en = 1'b0; i_en = 1'b0;
      b_dout = '0; i_dout = '0; rst_n = 1'b0;

      repeat (3) cycle();
      force_rst = 0;

      // Frame A: biases held back briefly so LOAD must not read inputs
      bpops = 0;
      gap = 3;
      push_frame(0);
      first_wr = -1;
      run_until_empty("doneA", 3000);
      chk("b2b_span", 32'(last_wr - first_wr), FR - 1);

      // Frame B: corners, 3-low/1-high backpressure, LOAD re-entry
      gap = 5;
      full_pat = 1;
      push_frame(1);
      run_until_empty("doneB", 6000);

      // Frame C: bias stall after 7 coefficients, bursty input
      full_pat = 2;
      rnd_in = 1;
      gate_at = bpops + 7;
      push_frame(2);
      run_until_empty("doneC", 4000);
      gate_at = -1;

      // Frame D: reset after 300 accepted samples
      rst_arm = 1;
      push_frame(2);
      for (int n = 0; n < 3000 && rst_arm; n++) cycle();
      chk("rst_hit", 32'(rst_arm), 0);

      // Frame E: fresh load after mid-frame reset
      gap = 3;
      push_frame(2);
      run_until_empty("doneE", 4000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bias_add_8.md
Name: bias_add_8

Overview:
- Downstream consumer of the layer-8 bias stream. Each frame it first loads N_KERN bias coefficients from the bias FIFO into a local register file.
- It then adds the matching bias to every convolution accumulator sample, which arrive channel-interleaved.
- It shifts and saturates each sum to the output width, then writes the result to the next stage's FIFO.
- All stream ports use the ap_fifo convention: read/empty_n on inputs, write/full_n on the output.

Parameters:
N_KERN, 16, number of output channels (biases per frame); channel index wraps at N_KERN
PIXELS, 64, output pixels per frame; a frame is PIXELS*N_KERN samples
COEFF_W, 16, signed bias width
ACC_W, 32, signed accumulator input width
OUT_W, 16, signed output width
SHIFT, 0, arithmetic right shift applied after the bias add (0..ACC_W-1)

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst_n  in  1  synchronous active-low reset
bias_V_dout  in  COEFF_W  bias FIFO head data, valid while bias_V_empty_n=1
bias_V_empty_n  in  1  bias FIFO non-empty
bias_V_read  out  1  pop bias FIFO this cycle
input_V_dout  in  ACC_W  accumulator FIFO head data
input_V_empty_n  in  1  accumulator FIFO non-empty
input_V_read  out  1  pop accumulator FIFO this cycle
output_V_din  out  OUT_W  result data
output_V_full_n  in  1  output FIFO has space
output_V_write  out  1  push output FIFO this cycle

Behaviour:
- Reset (ap_rst_n=0 at a clock edge, at any time including mid-frame):
  - state<=LOAD; bias_cnt, ch_cnt and pix_cnt <= 0; out_valid<=0; output_V_din<=0.
  - The bias register file is not cleared; it is overwritten by the next LOAD.
  - Every partially consumed frame is abandoned.
- State LOAD:
  - bias_V_read = bias_V_empty_n. On each pop, bias_reg[bias_cnt]<=bias_V_dout and bias_cnt++.
  - On the pop with bias_cnt=N_KERN-1: bias_cnt<=0, state<=RUN.
  - input_V_read=0 in LOAD.
  - The output register may still drain its held sample while in LOAD.
- State RUN:
  - bias_V_read=0.
  - accept = input_V_empty_n && (!out_valid || output_V_full_n); input_V_read = accept.
  - On accept:
    - sum = sext(input_V_dout, ACC_W+1) + sext(bias_reg[ch_cnt], ACC_W+1).
    - sh = sum >>> SHIFT.
    - res = sh saturated to the signed OUT_W range: sh > 2^(OUT_W-1)-1 gives max, sh < -2^(OUT_W-1) gives min.
    - output_V_din<=res; out_valid<=1.
    - ch_cnt++, wrapping at N_KERN-1 to 0. On each wrap, pix_cnt++.
    - On the accept with ch_cnt=N_KERN-1 and pix_cnt=PIXELS-1: counters <= 0, state<=LOAD.
  - With no accept and output_V_write=1: out_valid<=0.
- Output:
  - output_V_write = out_valid && output_V_full_n (combinational from full_n). It is never asserted while full_n=0.
  - output_V_din is held stable while out_valid=1 and the sample is not yet written.
- Latency and throughput:
  - Input popped at edge t; its result is presented from cycle t+1 and written on the first cycle from t+1 with full_n=1.
  - Throughput is 1 sample/cycle when streams are unblocked.
- Simultaneous write and accept: the held sample is written and the new result is registered in the same cycle; no bubble.
- Frame overhead is N_KERN cycles of LOAD at minimum. Bias reload happens every frame.
- Empty bias FIFO in LOAD: stall. Empty input FIFO in RUN: stall. The counters never advance without a pop.

Test Plan:
1. Reset, then push biases 0..15 and 1024 inputs all equal to 100, full_n=1 → 1024 writes with values 100+(i mod 16), back-to-back at 1/cycle; state returns to LOAD after sample 1023.
2. Bias = 0x7FFF on channel 0 and input = 0x7FFF0000 → output 0x7FFF (positive saturation). Bias = -1 and input = 0x80000000 → 0x8000 (negative saturation). Input 5 with bias -7 → 0xFFFE.
3. Run SHIFT=4, input 0x00000100, bias 0x0010 → (256+16)>>>4 = 17. Input -33 with bias 0 → -3 (arithmetic floor).
4. Toggle output_V_full_n with a 3-low/1-high pattern during RUN → no write while full_n=0; input_V_read drops while the output is held; no sample is lost or duplicated; order is preserved.
5. Gate bias_V_empty_n mid-LOAD after 7 biases, hold 10 cycles, then resume → bias_V_read and input_V_read stay 0 during the gap; channel 7 uses the 8th bias pushed.
6. Assert ap_rst_n=0 for 1 cycle at sample 300 of a frame → next cycle output_V_write=0 and state=LOAD; after a fresh bias load, the first output uses bias_reg[0].
